// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: 32-bit unsigned binary to 10-digit packed BCD,
// one shift per clock, with a significant-digit count alongside the result.
module product_bcd_converter (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  input  logic [31:0] product,
  output logic        busy,
  output logic        done,
  output logic [39:0] bcd,
  output logic [3:0]  ndigits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] bin_reg;
  logic [39:0] work_reg;
  logic [5:0]  cnt_reg;

  logic [39:0] work_adj;
  logic [39:0] work_next;
  logic [3:0]  nd_next;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_adj
      assign work_adj[4*gi+3:4*gi] = (work_reg[4*gi+3:4*gi] >= 4'd5) ?
                                     (work_reg[4*gi+3:4*gi] + 4'd3) :
                                     work_reg[4*gi+3:4*gi];
    end
  endgenerate

  // Correction and shift happen in the same cycle, so the shifted value is
  // already the final result on the last iteration.
  assign work_next = {work_adj[38:0], bin_reg[31]};

  always_comb begin
    nd_next = 4'd1;
    for (int k = 1; k < 10; k++) begin
      if (work_next[4*k +: 4] != 4'd0) nd_next = 4'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      work_reg  <= '0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      ndigits   <= 4'd1;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            bin_reg   <= product;
            work_reg  <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          work_reg <= work_next;
          bin_reg  <= {bin_reg[30:0], 1'b0};
          cnt_reg  <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            bcd       <= work_next;
            ndigits   <= nd_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Bench for product_bcd_converter: table of known conversions, random products
// against a divide-by-ten model, ignored restart, and mid-conversion reset.
module tb_product_bcd_converter;

  logic        clk;
  logic        res_n;
  logic        start;
  logic [31:0] product;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic [3:0]  ndigits;

  product_bcd_converter dut (
    .clk     (clk),
    .res_n   (res_n),
    .start   (start),
    .product (product),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ndigits (ndigits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] bcd;
    logic [3:0]  nd;
  } exp_t;

  typedef struct {
    logic [31:0] product;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  exp_t        sb_q[$];
  logic [39:0] prev_bcd;
  int          total_checks;
  int          pass_checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      pass_checks++;
  endtask

  function automatic logic [39:0] model_bcd(input logic [31:0] p);
    logic [39:0] r;
    logic [31:0] v;
    r = '0;
    v = p;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_nd(input logic [31:0] p);
    logic [3:0]  n;
    logic [31:0] v;
    n = 4'd1;
    v = p / 10;
    while (v != 0) begin
      n++;
      v = v / 10;
    end
    return n;
  endfunction

  // Drive start at a negedge, count busy cycles, pop the scoreboard on done.
  task automatic run_conv(input string name, input logic [31:0] p,
                          input logic [39:0] eb, input logic [3:0] en,
                          input bit restart_pulse);
    exp_t e;
    int   n;
    bit   hold_ok;
    start   = 1'b1;
    product = p;
    e.bcd = eb;
    e.nd  = en;
    sb_q.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    n       = 0;
    hold_ok = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (done || bcd !== prev_bcd) hold_ok = 1'b0;
      product = $urandom;
      if (restart_pulse && n == 10) begin
        start   = 1'b1;
        product = 32'd99;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    chk({name, " busy_cycles"}, 64'(n), 64'd32);
    chk({name, " hold"}, 64'(hold_ok), 64'd1);
    chk({name, " done"}, 64'({done, busy}), 64'b10);
    chk({name, " bcd"}, 64'(bcd), 64'(e.bcd));
    chk({name, " ndigits"}, 64'(ndigits), 64'(e.nd));
    $display("conv %s: product=%0d bcd=0x%010h ndigits=%0d busy_cycles=%0d",
             name, p, bcd, ndigits, n);
    prev_bcd = e.bcd;
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] rp;
    total_checks = 0;
    pass_checks  = 0;
    prev_bcd     = '0;

    vecs[0] = '{32'd0,          40'h0000000000, 4'd1};
    vecs[1] = '{32'd12345,      40'h0000012345, 4'd5};
    vecs[2] = '{32'hFFFFFFFF,   40'h4294967295, 4'd10};
    vecs[3] = '{32'd4294836225, 40'h4294836225, 4'd10};
    vecs[4] = '{32'd9,          40'h0000000009, 4'd1};
    vecs[5] = '{32'd10,         40'h0000000010, 4'd2};
    vecs[6] = '{32'd1000000000, 40'h1000000000, 4'd10};
    vecs[7] = '{32'd99999999,   40'h0099999999, 4'd8};

    res_n   = 1'b0;
    start   = 1'b0;
    product = '0;
    repeat (3) @(negedge clk);
    chk("reset busy/done", 64'({busy, done}), 64'b00);
    chk("reset bcd", 64'(bcd), 64'd0);
    chk("reset ndigits", 64'(ndigits), 64'd1);
    res_n = 1'b1;
    @(negedge clk);

    // Back-to-back table: each start issued straight from DONE.
    for (int i = 0; i < 8; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].product, vecs[i].bcd, vecs[i].nd, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rp = $urandom;
      run_conv($sformatf("rand%0d", i), rp, model_bcd(rp), model_nd(rp), 1'b0);
    end

    run_conv("ignored_restart", 32'd7, 40'h0000000007, 4'd1, 1'b1);

    // Reset in the middle of a conversion aborts it without publishing anything.
    start   = 1'b1;
    product = 32'd55555;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("midreset busy/done", 64'({busy, done}), 64'b00);
    chk("midreset bcd", 64'(bcd), 64'd0);
    chk("midreset ndigits", 64'(ndigits), 64'd1);
    $display("midreset: busy=%0b done=%0b bcd=0x%010h ndigits=%0d", busy, done, bcd, ndigits);
    @(negedge clk);
    res_n    = 1'b1;
    prev_bcd = '0;
    @(negedge clk);
    chk("post-reset idle", 64'({busy, done}), 64'b00);
    run_conv("after_reset", 32'd1000, 40'h0000001000, 4'd4, 1'b0);

    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
